// File: rtl/block_memory_responder_if.sv
// rtl/block_memory_responder_if.sv - block request/response bus between L1 cache and memory responder
interface block_memory_responder_if;
    logic         mem_write_req;
    logic [31:0]  mem_write_addr;
    logic [255:0] mem_write_data;
    logic         mem_write_valid;
    logic         mem_read_req;
    logic [31:0]  mem_read_addr;
    logic [255:0] mem_read_data;
    logic         mem_read_valid;
    logic         busy;

    // Cache side: issues requests, observes completions.
    modport master (
        output mem_write_req, mem_write_addr, mem_write_data,
        output mem_read_req, mem_read_addr,
        input  mem_write_valid, mem_read_data, mem_read_valid, busy
    );

    // Memory side: services requests.
    modport slave (
        input  mem_write_req, mem_write_addr, mem_write_data,
        input  mem_read_req, mem_read_addr,
        output mem_write_valid, mem_read_data, mem_read_valid, busy
    );
endinterface

// File: rtl/block_memory_responder.sv
// rtl/block_memory_responder.sv - fixed-latency 256-bit block memory responder for the L1 cache
module block_memory_responder #(
    parameter int DEPTH         = 1024,
    parameter int IDX_BITS      = 10,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 3
) (
    input  logic                     CLK,
    input  logic                     RESET,
    block_memory_responder_if.slave  mem
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_WR_WAIT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [3:0] RD_LAT = 4'(READ_LATENCY);
    localparam logic [3:0] WR_LAT = 4'(WRITE_LATENCY);

    // Backing store survives RESET; it only starts out as zero.
    logic [255:0] store_q [DEPTH] = '{default: '0};

    logic [1:0]          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [IDX_BITS-1:0] idx_q, idx_d;
    logic                served_wr_q, served_wr_d;
    logic                rvalid_q, rvalid_d;
    logic                wvalid_q, wvalid_d;
    logic [255:0]        rdata_q;
    logic                rd_en;
    logic                wr_en;

    // Address bits outside the block index are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem.mem_write_addr[31:IDX_BITS+5], mem.mem_write_addr[4:0],
                                mem.mem_read_addr[31:IDX_BITS+5],  mem.mem_read_addr[4:0]};

    // Next-state logic: accept (write first), count latency, complete, then wait for request release.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        served_wr_d = served_wr_q;
        rvalid_d    = 1'b0;
        wvalid_d    = 1'b0;
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem.mem_write_req) begin
                    idx_d       = mem.mem_write_addr[IDX_BITS+4:5];
                    cnt_d       = 4'd1;
                    served_wr_d = 1'b1;
                    state_d     = S_WR_WAIT;
                end else if (mem.mem_read_req) begin
                    idx_d       = mem.mem_read_addr[IDX_BITS+4:5];
                    cnt_d       = 4'd1;
                    served_wr_d = 1'b0;
                    state_d     = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == RD_LAT) begin
                    rd_en    = 1'b1;
                    rvalid_d = 1'b1;
                    cnt_d    = 4'd0;
                    state_d  = S_DONE;
                end
            end
            S_WR_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == WR_LAT) begin
                    wr_en    = 1'b1;
                    wvalid_d = 1'b1;
                    cnt_d    = 4'd0;
                    state_d  = S_DONE;
                end
            end
            default: begin
                // Hold here until the request just served is released, so a held req is not re-served.
                if (!(served_wr_q ? mem.mem_write_req : mem.mem_read_req)) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Control and response registers; reset aborts any in-flight transaction.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            served_wr_q <= 1'b0;
            rvalid_q    <= 1'b0;
            wvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            served_wr_q <= served_wr_d;
            rvalid_q    <= rvalid_d;
            wvalid_q    <= wvalid_d;
            if (rd_en) begin
                rdata_q <= store_q[idx_q];
            end
        end
    end

    // Store update; write data is sampled at completion, not at acceptance.
    always_ff @(posedge CLK) begin
        if (!RESET && wr_en) begin
            store_q[idx_q] <= mem.mem_write_data;
        end
    end

    assign mem.mem_read_data   = rdata_q;
    assign mem.mem_read_valid  = rvalid_q;
    assign mem.mem_write_valid = wvalid_q;
    assign mem.busy            = (state_q != S_IDLE);

endmodule
